// File: rtl/clock_sequencer_card_pkg.sv
// Shared constants for the clock sequencer card: FSM state encoding and the
// phase names the SUBLEQ datapath cards use to index phase_strobe.
package clock_sequencer_card_pkg;

    // Sequencer states; encoding is visible on the backplane debug header.
    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } seq_state_e;

    // Phase indices within one SUBLEQ instruction.
    localparam int PH_FETCH_A = 0;
    localparam int PH_FETCH_B = 1;
    localparam int PH_FETCH_C = 2;
    localparam int PH_READ    = 3;
    localparam int PH_SUB     = 4;
    localparam int PH_WRITE   = 5;
    localparam int PH_BRANCH  = 6;
    localparam int PH_SPARE   = 7;

    localparam int NUM_PHASES = PH_SPARE + 1;

endpackage

// File: rtl/clock_sequencer_card_prescaler.sv
// Divides clk into phase ticks: one tick every PRESCALE clk cycles while
// enabled. The counter is cleared whenever enable is low, so the first tick
// after enabling always lands PRESCALE edges later.
module clock_prescaler #(
    parameter int PRESCALE   = 1,
    parameter int PRESCALE_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST_CNT = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = enable && (r_cnt == LAST_CNT);

    // Count 0..PRESCALE-1 while enabled, wrap on tick, hold at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values regardless of statement or block order.
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_sequencer_card.sv
// Clock sequencer card: turns clk into a gated multi-phase execution sequence
// for the SUBLEQ datapath, with run / halt / single-step control. The machine
// only ever stops at an instruction boundary (tick of the last phase).
module clock_sequencer_card
    import clock_sequencer_card_pkg::*;
#(
    parameter int PHASES     = 8,
    parameter int PHASE_W    = 3,
    parameter int PRESCALE   = 1,
    parameter int PRESCALE_W = 8,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASES-1:0]  phase_strobe,
    output logic               cycle_start,
    output logic               running,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);
    localparam logic [PHASES-1:0]  STROBE_ONE = PHASES'(1);

    seq_state_e         r_state;
    logic               r_halt_pending;
    logic               r_running;
    logic               r_halted;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASES-1:0]  r_strobe;
    logic               r_cycle_start;
    logic [COUNT_W-1:0] r_count;

    logic               w_active;
    logic               w_tick;
    logic               w_boundary;

    assign w_active   = (r_state != HALTED);
    assign w_boundary = w_tick && (r_phase == LAST_PHASE);

    clock_prescaler #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_active),
        .tick   (w_tick)
    );

    // Phase counter, registered strobes and instruction counter; all advance on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase       <= '0;
            r_strobe      <= '0;
            r_cycle_start <= 1'b0;
            r_count       <= '0;
        end else if (w_tick) begin
            r_strobe      <= STROBE_ONE << r_phase;
            r_cycle_start <= (r_phase == '0);
            if (r_phase == LAST_PHASE) begin
                r_phase <= '0;
                r_count <= r_count + 1'b1;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end else begin
            r_strobe      <= '0;
            r_cycle_start <= 1'b0;
        end
    end

    // Run/halt/step FSM with registered running/halted flags and the deferred halt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= HALTED;
            r_halt_pending <= 1'b0;
            r_running      <= 1'b0;
            r_halted       <= 1'b1;
        end else begin
            case (r_state)
                HALTED: begin
                    r_halt_pending <= 1'b0;
                    if (step_req) begin
                        r_state   <= STEPPING;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end else if (run_req) begin
                        r_state   <= RUNNING;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (w_boundary) begin
                        // A halt arriving on the boundary tick itself stops here too.
                        if (r_halt_pending || halt_req || !run_req) begin
                            r_state   <= HALTED;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                        r_halt_pending <= 1'b0;
                    end else if (halt_req) begin
                        r_halt_pending <= 1'b1;
                    end
                end
                STEPPING: begin
                    if (w_boundary) begin
                        r_state   <= HALTED;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= HALTED;
                    r_halt_pending <= 1'b0;
                    r_running      <= 1'b0;
                    r_halted       <= 1'b1;
                end
            endcase
        end
    end

    assign phase        = r_phase;
    assign phase_strobe = r_strobe;
    assign cycle_start  = r_cycle_start;
    assign running      = r_running;
    assign halted       = r_halted;
    assign instr_count  = r_count;

endmodule

// File: tb/tb_clock_sequencer_card.sv
// Scoreboard bench for clock_sequencer_card. Stimulus pushes the expected
// strobe sequence (edge number, strobe, cycle_start, instr_count, halted) into
// a queue; a monitor pops and compares whenever the DUT shows a strobe.
// Two instances: PRESCALE=1/COUNT_W=16 and PRESCALE=4/COUNT_W=4.
module tb_clock_sequencer_card;

    typedef struct {
        int          cyc;
        logic [7:0]  strobe;
        logic        cs;
        logic [15:0] cnt;
        logic        halted;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clk = 1'b0;

    // Instance A: PRESCALE=1, COUNT_W=16
    logic        rst_n, run_req, halt_req, step_req;
    logic [2:0]  phase;
    logic [7:0]  phase_strobe;
    logic        cycle_start, running, halted;
    logic [15:0] instr_count;

    // Instance B: PRESCALE=4, COUNT_W=4
    logic        rst4_n, run4, halt4, step4;
    logic [2:0]  phase4;
    logic [7:0]  strobe4;
    logic        cs4, running4, halted4;
    logic [3:0]  count4;

    clock_sequencer_card #(
        .PHASES(8), .PHASE_W(3), .PRESCALE(1), .PRESCALE_W(8), .COUNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .phase(phase), .phase_strobe(phase_strobe),
        .cycle_start(cycle_start), .running(running), .halted(halted),
        .instr_count(instr_count)
    );

    clock_sequencer_card #(
        .PHASES(8), .PHASE_W(3), .PRESCALE(4), .PRESCALE_W(8), .COUNT_W(4)
    ) dut4 (
        .clk(clk), .rst_n(rst4_n), .run_req(run4), .halt_req(halt4),
        .step_req(step4), .phase(phase4), .phase_strobe(strobe4),
        .cycle_start(cs4), .running(running4), .halted(halted4),
        .instr_count(count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the 8 strobes of one instruction: first strobe at edge first_cyc,
    // then every spacing edges; count increments on the last-phase strobe.
    task automatic push_instr(input int sel, input int first_cyc, input int spacing,
                              input int cnt_before, input int modulo, input bit halt_end);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.cyc    = first_cyc + spacing * i;
            e.strobe = 8'(1 << i);
            e.cs     = (i == 0);
            e.cnt    = 16'((i == 7) ? (cnt_before + 1) % modulo : cnt_before % modulo);
            e.halted = halt_end && (i == 7);
            if (sel == 0) q.push_back(e);
            else          q4.push_back(e);
        end
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n === 1'b1) begin
            if (phase_strobe != 8'h00) begin
                if (q.size() == 0) begin
                    check("a_unexpected_strobe", 64'(phase_strobe), 64'h0);
                end else begin
                    e = q.pop_front();
                    check("a_strobe_edge",  64'(cyc),          64'(e.cyc));
                    check("a_strobe_value", 64'(phase_strobe), 64'(e.strobe));
                    check("a_cycle_start",  64'(cycle_start),  64'(e.cs));
                    check("a_instr_count",  64'(instr_count),  64'(e.cnt));
                    check("a_halted",       64'(halted),       64'(e.halted));
                end
            end else begin
                check("a_idle_cycle_start", 64'(cycle_start), 64'h0);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst4_n === 1'b1) begin
            if (strobe4 != 8'h00) begin
                if (q4.size() == 0) begin
                    check("b_unexpected_strobe", 64'(strobe4), 64'h0);
                end else begin
                    e = q4.pop_front();
                    check("b_strobe_edge",  64'(cyc),     64'(e.cyc));
                    check("b_strobe_value", 64'(strobe4), 64'(e.strobe));
                    check("b_cycle_start",  64'(cs4),     64'(e.cs));
                    check("b_instr_count",  64'(count4),  64'(e.cnt));
                    check("b_halted",       64'(halted4), 64'(e.halted));
                end
            end else begin
                check("b_idle_cycle_start", 64'(cs4), 64'h0);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        rst4_n = 1'b0; run4 = 1'b0; halt4 = 1'b0; step4 = 1'b0;
        #12;
        check("rst_halted",    64'(halted),       64'h1);
        check("rst_running",   64'(running),      64'h0);
        check("rst_phase",     64'(phase),        64'h0);
        check("rst_strobe",    64'(phase_strobe), 64'h0);
        check("rst_count",     64'(instr_count),  64'h0);
        check("rst4_halted",   64'(halted4),      64'h1);
        check("rst4_phase",    64'(phase4),       64'h0);
        tick();
        rst_n = 1'b1; rst4_n = 1'b1;
        repeat (3) tick();
        check("idle_halted", 64'(halted), 64'h1);

        // Single step: 8 consecutive strobes, halted on the 0x80 edge.
        n = cyc + 1;
        step_req = 1'b1;
        push_instr(0, n + 1, 1, 0, 65536, 1'b1);
        tick();
        step_req = 1'b0;
        check("step_running", 64'(running), 64'h1);
        check("step_halted",  64'(halted),  64'h0);
        repeat (12) tick();
        check("step_done_halted", 64'(halted),      64'h1);
        check("step_done_count",  64'(instr_count), 64'h1);
        check("step_drained",     64'(q.size()),    64'h0);

        // Run 3 instructions, halt pulse in phase 2 of the 4th; completes it.
        n = cyc + 1;
        run_req = 1'b1;
        for (int j = 0; j < 4; j++) push_instr(0, n + 1 + 8 * j, 1, 1 + j, 65536, j == 3);
        while (cyc < n + 26) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        while (cyc < n + 32) tick();
        run_req = 1'b0;
        check("halt_halted", 64'(halted),      64'h1);
        check("halt_count",  64'(instr_count), 64'h5);
        repeat (20) tick();
        check("halt_stays",   64'(halted),   64'h1);
        check("halt_drained", 64'(q.size()), 64'h0);

        // Step and run together: step wins, then RUNNING follows.
        n = cyc + 1;
        step_req = 1'b1; run_req = 1'b1;
        push_instr(0, n + 1, 1, 5, 65536, 1'b1);
        tick();
        step_req = 1'b0;
        check("sr_running", 64'(running), 64'h1);
        while (cyc < n + 8) tick();
        check("sr_halted_at_boundary", 64'(halted), 64'h1);
        push_instr(0, n + 10, 1, 6, 65536, 1'b0);
        tick();
        check("sr_rerun_running", 64'(running), 64'h1);
        check("sr_rerun_halted",  64'(halted),  64'h0);

        // Asynchronous reset mid-instruction at phase 5.
        while (cyc < n + 14) tick();
        check("pre_reset_phase", 64'(phase), 64'h5);
        rst_n = 1'b0; run_req = 1'b0;
        #1;
        check("mid_rst_halted",  64'(halted),       64'h1);
        check("mid_rst_running", 64'(running),      64'h0);
        check("mid_rst_phase",   64'(phase),        64'h0);
        check("mid_rst_strobe",  64'(phase_strobe), 64'h0);
        check("mid_rst_cs",      64'(cycle_start),  64'h0);
        check("mid_rst_count",   64'(instr_count),  64'h0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_halted", 64'(halted), 64'h1);

        // PRESCALE=4, COUNT_W=4: 17 instructions, strobes 4 edges apart, count wraps.
        n = cyc + 1;
        run4 = 1'b1;
        for (int j = 0; j < 17; j++) push_instr(1, n + 4 + 32 * j, 4, j, 16, j == 16);
        tick();
        check("p4_running", 64'(running4), 64'h1);
        check("p4_no_early_strobe", 64'(strobe4), 64'h0);
        while (cyc < n + 520) tick();
        run4 = 1'b0;
        while (cyc < n + 544) tick();
        check("p4_halted", 64'(halted4), 64'h1);
        check("p4_count",  64'(count4),  64'h1);
        repeat (12) tick();
        check("p4_drained", 64'(q4.size()), 64'h0);
        check("a_drained",  64'(q.size()),  64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
